// File: rtl/rr_arbiter_4to1_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_4to1_mux_ctrl
// Description : Round-robin arbiter in front of a shared N-bit 4-to-1 mux.
//               One pending requester wins each transfer. Its word goes
//               through the mux and into a single registered output slot.
//               The slot has a valid/ready handshake and a source tag.
// Ports       : clk        - rising-edge clock
//               rst_n      - synchronous reset, active-low
//               in_valid   - per-requester valid (bit k = requester k)
//               in_data0-3 - requester words (mux inputs 0..3)
//               in_ready   - one-hot capture strobe (combinational)
//               grant_sel  - mux select of current winner (combinational)
//               out_valid  - output slot holds a word
//               out_data   - registered mux output
//               out_src    - requester index that supplied out_data
//               out_ready  - consumer accepts out_data this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_4to1_mux_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   in_valid,
    input  logic [N-1:0] in_data0,
    input  logic [N-1:0] in_data1,
    input  logic [N-1:0] in_data2,
    input  logic [N-1:0] in_data3,
    output logic [3:0]   in_ready,
    output logic [1:0]   grant_sel,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic [1:0]   out_src,
    input  logic         out_ready
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [1:0]   r_ptr;
    logic [N-1:0] r_out_data;
    logic [1:0]   r_out_src;

    logic [1:0]   w_winner;
    logic [1:0]   w_idx;
    logic         w_found;
    logic         w_any_valid;
    logic         w_free;
    logic         w_capture;
    logic [N-1:0] w_mux_data;

    assign w_any_valid = |in_valid;
    assign out_valid   = (r_state == FULL);
    assign w_free      = !out_valid || out_ready;
    // rst_n gates the capture so that no requester sees in_ready during a
    // reset cycle; the word it would hand over would be thrown away.
    assign w_capture   = w_free && w_any_valid && rst_n;

    // Rotating priority search: ptr+1 first, ptr itself last. When nothing
    // is pending the default ptr+1 is left on the select.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr + 2'd1;
        w_idx    = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && in_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign grant_sel = w_winner;
    assign in_ready  = w_capture ? (4'b0001 << w_winner) : 4'b0000;

    always_comb begin
        w_mux_data = in_data0;
        case (grant_sel)
            2'd0:    w_mux_data = in_data0;
            2'd1:    w_mux_data = in_data1;
            2'd2:    w_mux_data = in_data2;
            default: w_mux_data = in_data3;
        endcase
    end

    // Next-state: a capture always leaves the slot full (covers the
    // simultaneous drain-and-refill case); a drain without refill empties it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: begin
                if (w_capture) begin
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                if (w_capture) begin
                    w_state_nxt = FULL;
                end else if (out_ready) begin
                    w_state_nxt = EMPTY;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_ptr      <= 2'd3;
            r_out_data <= '0;
            r_out_src  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_out_data <= w_mux_data;
                r_out_src  <= w_winner;
                r_ptr      <= w_winner;
            end
        end
    end

    assign out_data = r_out_data;
    assign out_src  = r_out_src;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_4to1_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter_4to1_mux_ctrl
// Description : Self-checking bench for rr_arbiter_4to1_mux_ctrl. Directed
//               scenarios followed by a randomized run against a
//               transfer-level reference model with a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_4to1_mux_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   in_valid;
    logic [N-1:0] din [4];
    logic [3:0]   in_ready;
    logic [1:0]   grant_sel;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic [1:0]   out_src;
    logic         out_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    rr_arbiter_4to1_mux_ctrl #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data0  (din[0]),
        .in_data1  (din[1]),
        .in_data2  (din[2]),
        .in_data3  (din[3]),
        .in_ready  (in_ready),
        .grant_sel (grant_sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) din[k] = '0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || out_src !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_out: valid=%b data=%h src=%0d, want 0/0/0", out_valid, out_data, out_src);
        end
        tests_run++;
        if (in_ready !== 4'b0000 || grant_sel !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_grant: in_ready=%b grant_sel=%0d, want 0000/0", in_ready, grant_sel);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        din[0] = 4'hA; din[1] = 4'hB; din[2] = 4'hC; din[3] = 4'hD;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_rdy = 4'b0001 << (i % 4);
            tests_run++;
            if (in_ready !== exp_rdy) begin
                tests_failed++;
                $display("FAIL rr_ready[%0d]: got %b want %b", i, in_ready, exp_rdy);
            end
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || out_src !== 2'(i % 4) || out_data !== 4'(4'hA + (i % 4))) begin
                tests_failed++;
                $display("FAIL rr_out[%0d]: valid=%b src=%0d data=%h want 1/%0d/%h",
                         i, out_valid, out_src, out_data, i % 4, 4'hA + (i % 4));
            end
        end
        in_valid = 4'b0000;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 4'hD || out_src !== 2'd3) begin
            tests_failed++;
            $display("FAIL rr_drain: valid=%b data=%h src=%0d want 0/d/3", out_valid, out_data, out_src);
        end
    endtask

    task automatic test_backpressure();
        din[2]    = 4'h5;
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 4'b0100) begin
            tests_failed++;
            $display("FAIL bp_capture: in_ready=%b want 0100", in_ready);
        end
        tick();
        in_valid = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 4'h5 || out_src !== 2'd2 || in_ready !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h src=%0d rdy=%b want 1/5/2/0000",
                         i, out_valid, out_data, out_src, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_fairness_pair();
        int         exp_seq [6] = '{3, 0, 3, 0, 1, 3};
        logic [3:0] vals    [6] = '{4'b1000, 4'b1001, 4'b1001, 4'b1011, 4'b1011, 4'b1011};
        for (int k = 0; k < 4; k++) din[k] = 4'(k + 1);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = vals[i];
            #1;
            tests_run++;
            if (in_ready !== (4'b0001 << exp_seq[i]) || grant_sel !== 2'(exp_seq[i])) begin
                tests_failed++;
                $display("FAIL pair_grant[%0d]: in_ready=%b sel=%0d want requester %0d",
                         i, in_ready, grant_sel, exp_seq[i]);
            end
            tick();
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_reset_while_full();
        din[1]    = 4'h9;
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        tick();
        in_valid = 4'b0000;
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 4'h9) begin
            tests_failed++;
            $display("FAIL rst_full_pre: valid=%b data=%h want 1/9", out_valid, out_data);
        end
        rst_n    = 1'b0;
        in_valid = 4'b0100;
        #1;
        tests_run++;
        if (in_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rst_full_ready: in_ready=%b want 0000", in_ready);
        end
        tick();
        rst_n    = 1'b1;
        in_valid = 4'b1111;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || out_src !== 2'd0) begin
            tests_failed++;
            $display("FAIL rst_full_out: valid=%b data=%h src=%0d want 0/0/0", out_valid, out_data, out_src);
        end
        tests_run++;
        if (in_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL rst_full_next: in_ready=%b want 0001", in_ready);
        end
        in_valid = 4'b0000;
        tick();
    endtask

    // Randomized run. The model tracks the slot contents and the last granted
    // requester; the winner is the first requester found walking upward
    // (mod 4) from the one after the last grant.
    task automatic test_random();
        logic [5:0] sb [$];
        logic [5:0] front;
        int         m_last;
        bit         m_valid;
        logic [N-1:0] m_data;
        int         m_src;
        int         waits [4];
        int         winner;
        bit         free, pend, cap;
        logic [3:0] exp_rdy;
        int         exp_sel;
        int         err_seen;

        do_reset();
        m_last  = 3;
        m_valid = 0;
        m_data  = '0;
        m_src   = 0;
        for (int k = 0; k < 4; k++) waits[k] = 0;
        err_seen = 0;

        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid  = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) din[k] = 4'($urandom);
            #1;

            pend   = (in_valid != 4'b0000);
            free   = !m_valid || out_ready;
            cap    = free && pend;
            winner = (m_last + 1) % 4;
            for (int s = 4; s >= 1; s--) begin
                if (in_valid[(m_last + s) % 4]) winner = (m_last + s) % 4;
            end
            exp_sel = winner;
            exp_rdy = cap ? (4'b0001 << winner) : 4'b0000;

            if (err_seen < 20) begin
                tests_run++;
                if (in_ready !== exp_rdy || grant_sel !== 2'(exp_sel) || out_valid !== m_valid
                    || out_data !== m_data || out_src !== 2'(m_src)) begin
                    tests_failed++;
                    err_seen++;
                    $display("FAIL rand_cycle[%0d]: rdy=%b sel=%0d v=%b d=%h s=%0d want %b/%0d/%b/%h/%0d",
                             cyc, in_ready, grant_sel, out_valid, out_data, out_src,
                             exp_rdy, exp_sel, m_valid, m_data, m_src);
                end
            end

            if (out_valid === 1'b1 && out_ready) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rand_dup[%0d]: transfer with empty scoreboard, data=%h", cyc, out_data);
                end else begin
                    front = sb.pop_front();
                    if ({out_src, out_data} !== front) begin
                        tests_failed++;
                        $display("FAIL rand_order[%0d]: got src=%0d data=%h want src=%0d data=%h",
                                 cyc, out_src, out_data, front[5:4], front[3:0]);
                    end
                end
            end

            if (in_ready != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    if (in_ready[k]) sb.push_back({2'(k), din[k]});
                end
            end

            if (cap) begin
                for (int k = 0; k < 4; k++) begin
                    if (k == winner || !in_valid[k]) waits[k] = 0;
                    else waits[k]++;
                end
                tests_run++;
                if (waits[0] > 3 || waits[1] > 3 || waits[2] > 3 || waits[3] > 3) begin
                    tests_failed++;
                    $display("FAIL rand_fair[%0d]: waits %0d/%0d/%0d/%0d exceed 3",
                             cyc, waits[0], waits[1], waits[2], waits[3]);
                end
                m_data  = din[winner];
                m_src   = winner;
                m_last  = winner;
                m_valid = 1;
            end else if (out_ready) begin
                m_valid = 0;
            end else begin
                for (int k = 0; k < 4; k++) if (!in_valid[k]) waits[k] = 0;
            end

            tick();
        end

        in_valid  = 4'b0000;
        out_ready = 1'b1;
        #1;
        if (out_valid === 1'b1) begin
            tests_run++;
            if (sb.size() == 0 || {out_src, out_data} !== sb[0]) begin
                tests_failed++;
                $display("FAIL rand_tail: last word src=%0d data=%h not at scoreboard head", out_src, out_data);
            end else begin
                void'(sb.pop_front());
            end
        end
        tick();
        tests_run++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rand_loss: %0d words never delivered, out_valid=%b", sb.size(), out_valid);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) din[k] = '0;
        #1;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_fairness_pair();
        test_reset_while_full();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
